// File: rtl/memory_slot_arbiter_pkg.sv
// Shared definitions for the memory slot arbiter: owner encoding and slot length.
package mem_slot_pkg;

    localparam int SLOT_TICKS = 4;

    typedef enum logic [2:0] {
        OWN_CPU    = 3'd0,
        OWN_VIDEO  = 3'd1,
        OWN_SOUND  = 3'd2,
        OWN_DSKINT = 3'd3,
        OWN_DSKEXT = 3'd4
    } ownerT;

    // Bit positions inside the non-CPU request vector.
    localparam int REQ_VIDEO  = 0;
    localparam int REQ_SOUND  = 1;
    localparam int REQ_DSKINT = 2;
    localparam int REQ_DSKEXT = 3;

endpackage

// File: rtl/memory_slot_arbiter_slot_picker.sv
// Next-slot owner selection: CPU on even slots, fixed priority with a
// round-robin disk tie-break on video-side slots.
module slot_picker
    import mem_slot_pkg::*;
(
    input  logic [3:0] reqVec,
    input  logic       parity,
    input  logic       rrLast,
    output ownerT      nextOwner,
    output logic       nextRrLast
);

    // parity is that of the slot being chosen; rrLast=1 means dskExt won last.
    always_comb begin
        nextOwner  = OWN_CPU;
        nextRrLast = rrLast;
        if (parity) begin
            if (reqVec[REQ_VIDEO]) begin
                nextOwner = OWN_VIDEO;
            end else if (reqVec[REQ_SOUND]) begin
                nextOwner = OWN_SOUND;
            end else if (reqVec[REQ_DSKINT] && reqVec[REQ_DSKEXT]) begin
                nextOwner  = rrLast ? OWN_DSKINT : OWN_DSKEXT;
                nextRrLast = ~rrLast;
            end else if (reqVec[REQ_DSKINT]) begin
                nextOwner  = OWN_DSKINT;
                nextRrLast = 1'b0;
            end else if (reqVec[REQ_DSKEXT]) begin
                nextOwner  = OWN_DSKEXT;
                nextRrLast = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_slot_arbiter.sv
// Time-slot scheduler for the shared RAM/ROM bus: alternating CPU and
// video-side slots of four clk8 ticks, with address mux and ack generation.
module memory_slot_arbiter
    import mem_slot_pkg::*;
#(
    parameter int ADDR_W = 22
) (
    input  logic              clk32,
    input  logic              _systemReset,
    input  logic              clk8_en_p,
    input  logic              _cpuAS,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic              videoReq,
    input  logic              soundReq,
    input  logic              dskIntReq,
    input  logic              dskExtReq,
    input  logic [ADDR_W-1:0] videoAddr,
    input  logic [ADDR_W-1:0] soundAddr,
    input  logic [ADDR_W-1:0] dskReadAddrInt,
    input  logic [ADDR_W-1:0] dskReadAddrExt,
    output logic [ADDR_W-1:0] memoryAddr,
    output logic              cpuBusControl,
    output logic              videoBusControl,
    output logic              memoryLatch,
    output logic [2:0]        slotOwner,
    output logic              videoAck,
    output logic              soundAck,
    output logic              dskReadAckInt,
    output logic              dskReadAckExt,
    output logic              cpuAck
);

    logic [1:0] phase;
    logic       parity;
    ownerT      owner;
    logic       rrLast;
    logic       slotEnd;
    logic [3:0] reqVec;
    ownerT      nextOwner;
    logic       nextRrLast;

    assign slotEnd     = clk8_en_p && (phase == 2'(SLOT_TICKS - 1));
    assign memoryLatch = slotEnd;

    assign cpuAck        = slotEnd && (owner == OWN_CPU)    && !_cpuAS;
    assign videoAck      = slotEnd && (owner == OWN_VIDEO)  && videoReq;
    assign soundAck      = slotEnd && (owner == OWN_SOUND)  && soundReq;
    assign dskReadAckInt = slotEnd && (owner == OWN_DSKINT) && dskIntReq;
    assign dskReadAckExt = slotEnd && (owner == OWN_DSKEXT) && dskExtReq;

    // A request just acked is still high this cycle; keep it out of the next pick.
    assign reqVec[REQ_VIDEO]  = videoReq  && !videoAck;
    assign reqVec[REQ_SOUND]  = soundReq  && !soundAck;
    assign reqVec[REQ_DSKINT] = dskIntReq && !dskReadAckInt;
    assign reqVec[REQ_DSKEXT] = dskExtReq && !dskReadAckExt;

    slot_picker uPicker (
        .reqVec     (reqVec),
        .parity     (~parity),
        .rrLast     (rrLast),
        .nextOwner  (nextOwner),
        .nextRrLast (nextRrLast)
    );

    always_ff @(posedge clk32 or negedge _systemReset) begin
        if (!_systemReset) begin
            phase  <= 2'd0;
            parity <= 1'b0;
            owner  <= OWN_CPU;
            rrLast <= 1'b1;
        end else if (clk8_en_p) begin
            phase <= phase + 2'd1;
            if (slotEnd) begin
                parity <= ~parity;
                owner  <= nextOwner;
                rrLast <= nextRrLast;
            end
        end
    end

    always_comb begin
        memoryAddr = cpuAddr;
        case (owner)
            OWN_VIDEO:  memoryAddr = videoAddr;
            OWN_SOUND:  memoryAddr = soundAddr;
            OWN_DSKINT: memoryAddr = dskReadAddrInt;
            OWN_DSKEXT: memoryAddr = dskReadAddrExt;
            default:    memoryAddr = cpuAddr;
        endcase
    end

    assign slotOwner       = owner;
    assign cpuBusControl   = (owner == OWN_CPU);
    assign videoBusControl = !cpuBusControl;

endmodule
